// File: rtl/prbs_checker_64.sv
// prbs_checker_64: self-synchronising PRBS7..31 checker with lock hunt and saturating error counters.
// Expected bits are taken from the received stream itself, so no seed search is needed.
module prbs_checker_64 #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           prbssel,
    input  logic [63:0]          rx_data,
    input  logic                 rx_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_bits,
    output logic [CNT_WIDTH-1:0] err_words,
    output logic [CNT_WIDTH-1:0] word_count
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    typedef enum logic [1:0] {OFF, PRIME, HUNT, LOCKED} state_t;
    state_t               state_q, state_d;
    logic [3:0]           sel_q;
    logic [63:0]          hist_q, mm_q, mm_d;
    logic [127:0]         win;
    logic                 v1_q, pulse_q, pulse_d, chg, bad_word;
    logic [RW-1:0]        run_q, run_d;
    logic [BW-1:0]        bad_q, bad_d;
    logic [CNT_WIDTH-1:0] eb_q, eb_d, ew_q, ew_d, wc_q, wc_d;
    logic [CNT_WIDTH:0]   eb_sum;
    logic [6:0]           tn, tk, nerr;

    function automatic logic supported(input logic [3:0] s);
        return s >= 4'd1 && s <= 4'd5;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return &c ? c : c + CNT_WIDTH'(1);
    endfunction

    // Tap offsets of x^n + x^k + 1: every expected bit is b[j-n] ^ b[j-k].
    always_comb begin
        tn = sel_q == 4'd2 ? 7'd9 : sel_q == 4'd3 ? 7'd15 : sel_q == 4'd4 ? 7'd23 : sel_q == 4'd5 ? 7'd31 : 7'd7;
        tk = sel_q == 4'd2 ? 7'd5 : sel_q == 4'd3 ? 7'd14 : sel_q == 4'd4 ? 7'd18 : sel_q == 4'd5 ? 7'd28 : 7'd6;
    end

    assign win      = {rx_data, hist_q};
    assign mm_d     = rx_data ^ win[7'd64 - tn +: 64] ^ win[7'd64 - tk +: 64];
    assign nerr     = 7'($countones(mm_q));
    assign bad_word = nerr != 7'd0;
    assign chg      = prbssel != sel_q;
    assign eb_sum   = {1'b0, eb_q} + {{(CNT_WIDTH - 6){1'b0}}, nerr};

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        bad_d   = bad_q;
        pulse_d = 1'b0;
        eb_d    = eb_q;
        ew_d    = ew_q;
        wc_d    = wc_q;
        if (chg) begin
            // A pattern switch discards whatever stage 2 holds from the old pattern.
            state_d = supported(prbssel) ? PRIME : OFF;
            run_d   = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                OFF: state_d = supported(sel_q) ? PRIME : OFF;
                PRIME: begin
                    state_d = v1_q ? HUNT : PRIME;
                    run_d   = '0;
                end
                HUNT: if (v1_q) begin
                    run_d   = bad_word ? '0 : run_q + RW'(1);
                    state_d = !bad_word && run_q == RW'(LOCK_COUNT - 1) ? LOCKED : HUNT;
                    bad_d   = '0;
                end
                LOCKED: if (v1_q) begin
                    pulse_d = bad_word;
                    wc_d    = sat_inc(wc_q);
                    ew_d    = bad_word ? sat_inc(ew_q) : ew_q;
                    eb_d    = eb_sum[CNT_WIDTH] ? '1 : eb_sum[CNT_WIDTH-1:0];
                    bad_d   = bad_word ? bad_q + BW'(1) : '0;
                    if (bad_word && bad_q == BW'(UNLOCK_COUNT - 1)) begin
                        state_d = HUNT;
                        run_d   = '0;
                    end
                end
                default: state_d = OFF;
            endcase
        end
        if (clear) begin
            eb_d = '0;
            ew_d = '0;
            wc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            sel_q   <= '0;
            hist_q  <= '0;
            mm_q    <= '0;
            v1_q    <= 1'b0;
            run_q   <= '0;
            bad_q   <= '0;
            pulse_q <= 1'b0;
            eb_q    <= '0;
            ew_q    <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= prbssel;
            v1_q    <= rx_valid;
            run_q   <= run_d;
            bad_q   <= bad_d;
            pulse_q <= pulse_d;
            eb_q    <= eb_d;
            ew_q    <= ew_d;
            wc_q    <= wc_d;
            if (rx_valid) begin
                hist_q <= rx_data;
                mm_q   <= mm_d;
            end
        end
    end

    assign locked     = state_q == LOCKED;
    assign err_pulse  = pulse_q;
    assign err_bits   = eb_q;
    assign err_words  = ew_q;
    assign word_count = wc_q;
endmodule

// File: tb/tb_prbs_checker_64.sv
// tb_prbs_checker_64: table-driven and directed checks of prbs_checker_64 against a word-level
// reference model fed by an independent bit-serial PRBS generator.
module tb_prbs_checker_64;
    logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, clear = 1'b0;
    logic [3:0]  prbssel = 4'd0;
    logic [63:0] rx_data = '0;
    logic        locked, err_pulse;
    logic [31:0] err_bits, err_words, word_count;

    always #5 clk = ~clk;

    prbs_checker_64 dut (
        .clk(clk), .rst(rst), .prbssel(prbssel), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_bits(err_bits),
        .err_words(err_words), .word_count(word_count)
    );

    int total = 0, bad = 0, pulse_seen = 0;
    localparam int S_OFF = 0, S_PRIME = 1, S_HUNT = 2, S_LOCK = 3;
    localparam longint CMAX = 64'hFFFF_FFFF;
    int          m_st = S_OFF, m_run = 0, m_bad = 0, m_pn = 0;
    logic [3:0]  m_sel = 4'd0;
    logic [63:0] m_hist = '0;
    bit          m_pv = 0, m_pulse = 0;
    longint      m_wc = 0, m_eb = 0, m_ew = 0;
    bit          gq[$];
    int          g_n, g_k;

    typedef struct {
        logic [3:0] sel;
        int         words;
        bit         gap;
        int         flip;
        bit         lk;
        longint     wc, eb, ew;
    } vec_t;
    vec_t tbl[12];

    function automatic int tap_n(input logic [3:0] s);
        return s == 2 ? 9 : s == 3 ? 15 : s == 4 ? 23 : s == 5 ? 31 : 7;
    endfunction

    function automatic int tap_k(input logic [3:0] s);
        return s == 2 ? 5 : s == 3 ? 14 : s == 4 ? 18 : s == 5 ? 28 : 6;
    endfunction

    function automatic bit sup(input logic [3:0] s);
        return s >= 1 && s <= 5;
    endfunction

    function automatic int count_err(input logic [63:0] d, input logic [63:0] h, input logic [3:0] s);
        bit b[128];
        int n = tap_n(s), k = tap_k(s), c = 0;
        for (int i = 0; i < 64; i++) begin
            b[i] = h[i];
            b[64 + i] = d[i];
        end
        for (int j = 64; j < 128; j++) if (b[j] != (b[j - n] ^ b[j - k])) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level behaviour: each valid word is judged one cycle after it is captured.
    task automatic model_step();
        bit changed;
        if (rst) begin
            m_st = S_OFF; m_run = 0; m_bad = 0; m_sel = 0; m_hist = 0; m_pv = 0; m_pn = 0;
            m_pulse = 0; m_wc = 0; m_eb = 0; m_ew = 0;
            return;
        end
        changed = prbssel != m_sel;
        m_pulse = 0;
        if (changed) begin
            m_st = sup(prbssel) ? S_PRIME : S_OFF;
            m_run = 0;
            m_bad = 0;
        end else if (m_st == S_OFF) begin
            m_st = sup(prbssel) ? S_PRIME : S_OFF;
        end else if (m_pv) begin
            if (m_st == S_PRIME) begin
                m_st = S_HUNT;
                m_run = 0;
            end else if (m_st == S_HUNT) begin
                m_run = m_pn == 0 ? m_run + 1 : 0;
                if (m_run == 16) begin m_st = S_LOCK; m_bad = 0; end
            end else begin
                m_wc = m_wc + 1 > CMAX ? CMAX : m_wc + 1;
                m_eb = m_eb + m_pn > CMAX ? CMAX : m_eb + m_pn;
                if (m_pn != 0) m_ew = m_ew + 1 > CMAX ? CMAX : m_ew + 1;
                m_pulse = m_pn != 0;
                m_bad = m_pn != 0 ? m_bad + 1 : 0;
                if (m_bad == 4) begin m_st = S_HUNT; m_run = 0; end
            end
        end
        if (clear) begin m_wc = 0; m_eb = 0; m_ew = 0; end
        m_sel = prbssel;
        m_pv = rx_valid;
        if (rx_valid) begin
            m_pn = count_err(rx_data, m_hist, prbssel);
            m_hist = rx_data;
        end
    endtask

    task automatic cyc(input logic [63:0] d, input logic v, input logic c);
        rx_data = d; rx_valid = v; clear = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (err_pulse) pulse_seen++;
        chk("cyc_locked", 64'(locked), 64'(m_st == S_LOCK));
        chk("cyc_err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("cyc_word_count", 64'(word_count), m_wc);
        chk("cyc_err_bits", 64'(err_bits), m_eb);
        chk("cyc_err_words", 64'(err_words), m_ew);
    endtask

    task automatic gen_init(input logic [3:0] s);
        g_n = tap_n(s);
        g_k = tap_k(s);
        gq.delete();
        for (int i = 0; i < 31; i++) gq.push_back(1'($urandom_range(1)));
        gq[30] = 1'b1;
    endtask

    task automatic gen_word(output logic [63:0] w);
        bit nb;
        for (int i = 0; i < 64; i++) begin
            nb = gq[31 - g_n] ^ gq[31 - g_k];
            gq.push_back(nb);
            void'(gq.pop_front());
            w[i] = nb;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc('0, 0, 0);
        cyc('0, 0, 0);
        chk("reset_locked", 64'(locked), 0);
        chk("reset_count", 64'(word_count), 0);
        rst = 1'b0;
    endtask

    task automatic start_stream(input logic [3:0] s);
        prbssel = s;
        gen_init(s);
        cyc('0, 0, 0);
        cyc('0, 0, 0);
    endtask

    task automatic clean_words(input int cnt);
        logic [63:0] w;
        for (int i = 0; i < cnt; i++) begin
            gen_word(w);
            cyc(w, 1, 0);
        end
    endtask

    initial begin
        logic [63:0] w;
        tbl[0]  = '{4'd5, 17,   1'b0, 0,   1'b1, 0,   0, 0};
        tbl[1]  = '{4'd5, 16,   1'b0, 0,   1'b0, 0,   0, 0};
        tbl[2]  = '{4'd1, 1000, 1'b0, 0,   1'b1, 983, 0, 0};
        tbl[3]  = '{4'd2, 1000, 1'b0, 0,   1'b1, 983, 0, 0};
        tbl[4]  = '{4'd3, 1000, 1'b0, 0,   1'b1, 983, 0, 0};
        tbl[5]  = '{4'd4, 1000, 1'b0, 0,   1'b1, 983, 0, 0};
        tbl[6]  = '{4'd5, 1000, 1'b0, 0,   1'b1, 983, 0, 0};
        tbl[7]  = '{4'd5, 300,  1'b0, 100, 1'b1, 283, 3, 1};
        tbl[8]  = '{4'd5, 300,  1'b1, 100, 1'b1, 283, 3, 1};
        tbl[9]  = '{4'd1, 300,  1'b1, 100, 1'b1, 283, 3, 1};
        tbl[10] = '{4'd0, 100,  1'b0, 0,   1'b0, 0,   0, 0};
        tbl[11] = '{4'd9, 100,  1'b0, 0,   1'b0, 0,   0, 0};
        @(negedge clk);
        foreach (tbl[t]) begin
            do_reset();
            start_stream(tbl[t].sel);
            for (int i = 1; i <= tbl[t].words; i++) begin
                while (tbl[t].gap && $urandom_range(1) == 0) cyc({$urandom, $urandom}, 0, 0);
                gen_word(w);
                if (i == tbl[t].flip) w[10] = ~w[10];
                cyc(w, 1, 0);
            end
            for (int i = 0; i < 3; i++) cyc('0, 0, 0);
            chk($sformatf("tbl%0d_locked", t), 64'(locked), 64'(tbl[t].lk));
            chk($sformatf("tbl%0d_word_count", t), 64'(word_count), tbl[t].wc);
            chk($sformatf("tbl%0d_err_bits", t), 64'(err_bits), tbl[t].eb);
            chk($sformatf("tbl%0d_err_words", t), 64'(err_words), tbl[t].ew);
        end

        // lock timing on PRBS31
        do_reset();
        start_stream(4'd5);
        clean_words(17);
        chk("lock_before_18", 64'(locked), 0);
        clean_words(1);
        chk("lock_on_18", 64'(locked), 1);
        clean_words(1);
        chk("wc_step1", 64'(word_count), 1);
        clean_words(1);
        chk("wc_step2", 64'(word_count), 2);

        // single bit flip on locked PRBS7
        do_reset();
        start_stream(4'd1);
        clean_words(40);
        pulse_seen = 0;
        gen_word(w);
        cyc(w ^ (64'd1 << 10), 1, 0);
        clean_words(3);
        chk("flip_err_bits", 64'(err_bits), 3);
        chk("flip_err_words", 64'(err_words), 1);
        chk("flip_locked", 64'(locked), 1);
        chk("flip_pulse_count", 64'(pulse_seen), 1);

        // four corrupted words drop lock, counters hold, then relock
        for (int i = 0; i < 4; i++) begin
            gen_word(w);
            cyc(~w, 1, 0);
        end
        chk("unlock_after3", 64'(locked), 1);
        clean_words(1);
        chk("unlock_after4", 64'(locked), 0);
        chk("unlock_err_words", 64'(err_words), 5);
        clean_words(3);
        chk("hunt_hold_err_words", 64'(err_words), 5);
        clean_words(30);
        chk("relock", 64'(locked), 1);

        // saturation from preset counters, then clear racing an errored word
        force dut.wc_q = 32'hFFFF_FFFE;
        force dut.ew_q = 32'hFFFF_FFFE;
        force dut.eb_q = 32'hFFFF_FFF0;
        #1;
        release dut.wc_q;
        release dut.ew_q;
        release dut.eb_q;
        m_wc = 64'hFFFF_FFFE;
        m_ew = 64'hFFFF_FFFE;
        m_eb = 64'hFFFF_FFF0;
        for (int i = 0; i < 2; i++) begin
            gen_word(w);
            cyc(~w, 1, 0);
        end
        clean_words(3);
        chk("sat_word_count", 64'(word_count), CMAX);
        chk("sat_err_words", 64'(err_words), CMAX);
        chk("sat_err_bits", 64'(err_bits), CMAX);
        gen_word(w);
        cyc(~w, 1, 0);
        gen_word(w);
        cyc(w, 1, 1);
        chk("clear_word_count", 64'(word_count), 0);
        chk("clear_err_words", 64'(err_words), 0);
        chk("clear_err_bits", 64'(err_bits), 0);
        chk("clear_keeps_lock", 64'(locked), 1);

        // pattern change mid-stream, relock, then reset while locked
        prbssel = 4'd3;
        gen_init(4'd3);
        clean_words(1);
        chk("sel_change_unlock", 64'(locked), 0);
        clean_words(30);
        chk("relock_prbs15", 64'(locked), 1);
        chk("relock_counting", 64'(word_count != 0), 1);
        rst = 1'b1;
        clean_words(1);
        chk("rst_locked", 64'(locked), 0);
        chk("rst_err_pulse", 64'(err_pulse), 0);
        chk("rst_word_count", 64'(word_count), 0);
        chk("rst_err_bits", 64'(err_bits), 0);
        chk("rst_err_words", 64'(err_words), 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
